// File: rtl/fmap_buf_pkg.sv
// Shared constants for the feature-map frame buffer: FSM encoding, frame
// counter width and the RAM address-width helper.
package fmap_buf_pkg;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    localparam int FCNT_W = 16;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// One channel bank: single write port, single registered read port.
// Reads see the pre-write contents when both ports hit the same address.
module fmap_bank_ram #(
    parameter int DEPTH = 576,
    parameter int DW    = 20,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fmap_frame_buffer.sv
// Raster-order capture of one CH-channel feature map with random-access reads.
// Define FBUF_RELU_EN to clamp negative samples to zero on write.
module fmap_frame_buffer
    import fmap_buf_pkg::*;
#(
    parameter int CH = 3,
    parameter int DW = 20,
    parameter int FW = 24,
    parameter int FH = 24,
    parameter int XW = $clog2(FW),
    parameter int YW = $clog2(FH),
    parameter int CW = (CH > 1 ? $clog2(CH) : 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_in_valid,
    input  logic [CH*DW-1:0]  i_in_fmap,
    input  logic              i_release,
    input  logic              i_rd_req,
    input  logic [CW-1:0]     i_rd_ch,
    input  logic [XW-1:0]     i_rd_x,
    input  logic [YW-1:0]     i_rd_y,
    output logic              o_rd_valid,
    output logic [DW-1:0]     o_rd_data,
    output logic              o_rd_err,
    output logic              o_frame_done,
    output logic              o_full,
    output logic              o_overflow,
    output logic [XW-1:0]     o_wr_x,
    output logic [YW-1:0]     o_wr_y,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    localparam int DEPTH = FW * FH;
    localparam int AW    = addr_w(DEPTH);

    localparam logic [XW-1:0] X_LAST = XW'(FW - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FH - 1);
    localparam logic [CW:0]   CH_L   = (CW + 1)'(CH);
    localparam logic [XW:0]   FW_L   = (XW + 1)'(FW);
    localparam logic [YW:0]   FH_L   = (YW + 1)'(FH);

    logic [0:0]        state_q;
    logic [XW-1:0]     wr_x_q;
    logic [YW-1:0]     wr_y_q;
    logic [AW-1:0]     wr_addr_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic              done_q;
    logic              ovf_q;
    logic              wr_en;

    logic              rd_in_range;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic              rd_zero_q;
    logic [CW-1:0]     rd_ch_q;
    logic [DW-1:0]     rd_mux;
    logic [DW-1:0]     bank_q [CH];

    assign wr_en = i_in_valid && (state_q == ST_FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_addr_q   <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (i_in_valid) begin
                        if (wr_x_q == X_LAST) begin
                            wr_x_q <= '0;
                            if (wr_y_q == Y_LAST) begin
                                wr_y_q      <= '0;
                                wr_addr_q   <= '0;
                                state_q     <= ST_FULL;
                                done_q      <= 1'b1;
                                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                            end else begin
                                wr_y_q    <= wr_y_q + YW'(1);
                                wr_addr_q <= wr_addr_q + AW'(1);
                            end
                        end else begin
                            wr_x_q    <= wr_x_q + XW'(1);
                            wr_addr_q <= wr_addr_q + AW'(1);
                        end
                    end
                end
                default: begin
                    if (i_in_valid)
                        ovf_q <= 1'b1;
                    if (i_release)
                        state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign rd_in_range = ({1'b0, i_rd_ch} < CH_L) &&
                         ({1'b0, i_rd_x}  < FW_L) &&
                         ({1'b0, i_rd_y}  < FH_L);
    assign rd_addr = AW'(i_rd_y) * AW'(FW) + AW'(i_rd_x);

    for (genvar c = 0; c < CH; c++) begin : g_bank
        logic [DW-1:0] sample;
        logic [DW-1:0] wr_data;

        assign sample = i_in_fmap[c*DW +: DW];
`ifdef FBUF_RELU_EN
        assign wr_data = sample[DW-1] ? '0 : sample;
`else
        assign wr_data = sample;
`endif

        fmap_bank_ram #(
            .DEPTH (DEPTH),
            .DW    (DW),
            .AW    (AW)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_addr (wr_addr_q),
            .wr_data (wr_data),
            .rd_en   (i_rd_req && rd_in_range),
            .rd_addr (rd_addr),
            .rd_data (bank_q[c])
        );
    end

    // Bank outputs only update on in-range reads, so the held channel select
    // plus a zero flag reproduce "hold last value" without an extra data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_ch_q    <= '0;
        end else begin
            rd_valid_q <= i_rd_req;
            if (i_rd_req) begin
                rd_err_q  <= !rd_in_range;
                rd_zero_q <= !rd_in_range;
                if (rd_in_range)
                    rd_ch_q <= i_rd_ch;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (rd_ch_q == CW'(c))
                rd_mux = bank_q[c];
        end
    end

    assign o_rd_valid   = rd_valid_q;
    assign o_rd_err     = rd_valid_q && rd_err_q;
    assign o_rd_data    = rd_zero_q ? '0 : rd_mux;
    assign o_frame_done = done_q;
    assign o_full       = (state_q == ST_FULL);
    assign o_overflow   = ovf_q;
    assign o_wr_x       = wr_x_q;
    assign o_wr_y       = wr_y_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fmap_frame_buffer.sv
// Scoreboard bench for fmap_frame_buffer on a 4x3, 3-channel frame.
// Expected read responses are queued at issue time and checked by a monitor.
module tb_fmap_frame_buffer;

    localparam int CH = 3;
    localparam int DW = 20;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_in_valid = 1'b0;
    logic [CH*DW-1:0]  i_in_fmap = '0;
    logic              i_release = 1'b0;
    logic              i_rd_req = 1'b0;
    logic [CW-1:0]     i_rd_ch = '0;
    logic [XW-1:0]     i_rd_x = '0;
    logic [YW-1:0]     i_rd_y = '0;
    logic              o_rd_valid;
    logic [DW-1:0]     o_rd_data;
    logic              o_rd_err;
    logic              o_frame_done;
    logic              o_full;
    logic              o_overflow;
    logic [XW-1:0]     o_wr_x;
    logic [YW-1:0]     o_wr_y;
    logic [15:0]       o_frame_cnt;

    fmap_frame_buffer #(
        .CH (CH),
        .DW (DW),
        .FW (FW),
        .FH (FH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_in_valid   (i_in_valid),
        .i_in_fmap    (i_in_fmap),
        .i_release    (i_release),
        .i_rd_req     (i_rd_req),
        .i_rd_ch      (i_rd_ch),
        .i_rd_x       (i_rd_x),
        .i_rd_y       (i_rd_y),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_rd_err     (o_rd_err),
        .o_frame_done (o_frame_done),
        .o_full       (o_full),
        .o_overflow   (o_overflow),
        .o_wr_x       (o_wr_x),
        .o_wr_y       (o_wr_y),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

`ifdef FBUF_RELU_EN
    localparam int NEG1 = 0;
    localparam int NEG2 = 0;
`else
    localparam int NEG1 = 'hFFFFB;
    localparam int NEG2 = 'h80000;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [CH*DW-1:0] pack(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        i_rd_req   = 1'b0;
        i_release  = 1'b0;
    endtask

    task automatic beat(input int a, input int b, input int c);
        i_in_valid = 1'b1;
        i_in_fmap  = pack(a, b, c);
    endtask

    task automatic rd(input int ch, input int x, input int y, input logic err,
                      input int data, input string name);
        exp_t e;
        i_rd_req = 1'b1;
        i_rd_ch  = CW'(ch);
        i_rd_x   = XW'(x);
        i_rd_y   = YW'(y);
        e.name = name;
        e.err  = err;
        e.data = DW'(data);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && o_rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_read: got data 0x%0h err %0b, expected no response",
                         o_rd_data, o_rd_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_err"}, 32'(o_rd_err), 32'(e.err));
                chk({e.name, "_data"}, 32'(o_rd_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_full", 32'(o_full), 0);
        chk("rst_cnt", 32'(o_frame_cnt), 0);
        chk("rst_wr_x", 32'(o_wr_x), 0);
        chk("rst_wr_y", 32'(o_wr_y), 0);
        chk("rst_ovf", 32'(o_overflow), 0);
        chk("rst_rd_valid", 32'(o_rd_valid), 0);
        chk("rst_rd_data", 32'(o_rd_data), 0);
        chk("rst_done", 32'(o_frame_done), 0);
        reset = 1'b0;

        // Frame 1: channel c of beat i carries 100*c + i.
        for (int i = 0; i < 12; i++) begin
            beat(i, 100 + i, 200 + i);
            step();
            chk($sformatf("f1_done_beat%0d", i), 32'(o_frame_done), (i == 11) ? 1 : 0);
        end
        chk("f1_full", 32'(o_full), 1);
        chk("f1_cnt", 32'(o_frame_cnt), 1);
        chk("f1_wr_x", 32'(o_wr_x), 0);
        chk("f1_wr_y", 32'(o_wr_y), 0);
        step();
        chk("f1_done_pulse_end", 32'(o_frame_done), 0);

        rd(2, 3, 2, 1'b0, 211, "rd_c2x3y2");
        step();
        rd(0, 0, 0, 1'b0, 0, "rd_c0x0y0");
        step();
        rd(1, 1, 1, 1'b0, 105, "rd_c1x1y1");
        step();
        step();

        // Beats while FULL are dropped.
        beat('h55555, 'h55555, 'h55555);
        step();
        chk("ovf_set", 32'(o_overflow), 1);
        beat('h55555, 'h55555, 'h55555);
        step();
        chk("ovf_still_full", 32'(o_full), 1);
        rd(0, 0, 0, 1'b0, 0, "rd_after_ovf");
        step();
        step();
        chk("ovf_sticky", 32'(o_overflow), 1);

        i_release = 1'b1;
        beat(9, 9, 9);
        step();
        chk("rel_full", 32'(o_full), 0);
        chk("rel_beat_dropped_wr_x", 32'(o_wr_x), 0);
        beat(7, 7, 7);
        step();
        chk("post_rel_wr_x", 32'(o_wr_x), 1);
        rd(0, 0, 0, 1'b0, 7, "rd_seven_c0");
        step();
        rd(2, 0, 0, 1'b0, 7, "rd_seven_c2");
        step();

        // Read and write of (1,0) in the same cycle.
        beat(33, 33, 33);
        rd(0, 1, 0, 1'b0, 1, "collide_old");
        step();
        rd(0, 1, 0, 1'b0, 33, "collide_new");
        step();

        rd(3, 0, 0, 1'b1, 0, "oor_ch");
        step();
        rd(0, 0, 3, 1'b1, 0, "oor_y");
        step();
        step();
        chk("idle_valid", 32'(o_rd_valid), 0);
        chk("idle_err", 32'(o_rd_err), 0);
        chk("idle_hold_zero", 32'(o_rd_data), 0);
        rd(1, 0, 0, 1'b0, 7, "rd_after_oor");
        step();
        step();
        chk("idle_hold_data", 32'(o_rd_data), 7);

        // Partial frame: 2 beats already in, 3 more gives 5.
        for (int i = 0; i < 3; i++) begin
            beat(50 + i, 50 + i, 50 + i);
            step();
        end
        chk("mid_wr_x", 32'(o_wr_x), 1);
        chk("mid_wr_y", 32'(o_wr_y), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_wr_x", 32'(o_wr_x), 0);
        chk("mrst_wr_y", 32'(o_wr_y), 0);
        chk("mrst_cnt", 32'(o_frame_cnt), 0);
        chk("mrst_ovf", 32'(o_overflow), 0);
        chk("mrst_full", 32'(o_full), 0);

        for (int i = 0; i < 12; i++) begin
            beat(1000 + i, 1100 + i, 1200 + i);
            step();
            chk($sformatf("f2_done_beat%0d", i), 32'(o_frame_done), (i == 11) ? 1 : 0);
        end
        chk("f2_cnt", 32'(o_frame_cnt), 1);
        chk("f2_full", 32'(o_full), 1);
        rd(0, 0, 0, 1'b0, 1000, "f2_c0x0y0");
        step();
        rd(2, 3, 2, 1'b0, 1211, "f2_c2x3y2");
        step();
        step();

        // Negative samples: kept as-is, or zeroed with the clamp enabled.
        i_release = 1'b1;
        step();
        chk("rel2_full", 32'(o_full), 0);
        beat(3, 'hFFFFB, 'h80000);
        step();
        rd(0, 0, 0, 1'b0, 3, "neg_c0_pos");
        step();
        rd(1, 0, 0, 1'b0, NEG1, "neg_c1");
        step();
        rd(2, 0, 0, 1'b0, NEG2, "neg_c2");
        step();
        step();
        step();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
